seg_scan_ctrl: RTL

Multiplexed 4-digit 7-segment scan controller. Takes a binary value (0..9999), decimal-point mask and sign, and converts the value to BCD with a sequential double-dabble engine. It then time-multiplexes the digits onto the sel/seg pair consumed by the 74HC595 serial driver, so one driver instance can be shared by all four digits. Leading-zero blanking and sign placement are handled here.

---
 rtl/seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : 4-digit 7-segment scan controller with double-dabble BCD engine
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter logic [15:0] CNT_MAX = 16'd49_999,
    parameter logic [13:0] VAL_MAX = 14'd9999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] data,
    input  logic        data_vld,
    input  logic [3:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic        busy,
    output logic [3:0]  sel,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        w_load, w_use_pend, w_to_pend, w_commit;

    logic [13:0] w_data_sat, w_src_data;
    logic [3:0]  w_src_point;
    logic        w_src_sign;

    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_iter;
    logic [3:0]  r_cv_point;
    logic        r_cv_sign;

    logic        r_pend_vld;
    logic [13:0] r_pend_data;
    logic [3:0]  r_pend_point;
    logic        r_pend_sign;

    logic [15:0] r_disp_bcd;
    logic [3:0]  r_disp_point;
    logic        r_disp_sign;

    logic [15:0] r_cnt;
    logic [1:0]  r_dig;
    logic [3:0]  r_sel;
    logic [7:0]  r_seg;

    logic [11:0] w_bcd_adj;
    logic [3:0]  w_nz, w_sig, w_nibble;
    logic [1:0]  w_minus_pos;
    logic        w_minus_ok;
    logic [7:0]  w_seg_nxt;

    function automatic logic [7:0] f_dec(input logic [3:0] n);
        case (n)
            4'd0:    f_dec = 8'hC0;
            4'd1:    f_dec = 8'hF9;
            4'd2:    f_dec = 8'hA4;
            4'd3:    f_dec = 8'hB0;
            4'd4:    f_dec = 8'h99;
            4'd5:    f_dec = 8'h92;
            4'd6:    f_dec = 8'h82;
            4'd7:    f_dec = 8'hF8;
            4'd8:    f_dec = 8'h80;
            4'd9:    f_dec = 8'h90;
            default: f_dec = 8'hFF;
        endcase
    endfunction

    // Thousands nibble never needs the +3 step: input is capped at 9999.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                      r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_nz
        assign w_nz[gi] = |r_disp_bcd[gi*4 +: 4];
    end

    always_comb begin
        w_data_sat  = (data > VAL_MAX) ? VAL_MAX : data;
        w_src_data  = w_use_pend ? r_pend_data  : w_data_sat;
        w_src_point = w_use_pend ? r_pend_point : point;
        w_src_sign  = w_use_pend ? r_pend_sign  : sign;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_use_pend  = 1'b0;
        w_to_pend   = 1'b0;
        w_commit    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                busy      = 1'b1;
                w_to_pend = data_vld;
                if (r_iter == 4'd13) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                w_commit = 1'b1;
                // A strobe landing in DONE is newer than the pending slot.
                if (data_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CONV;
                end else if (r_pend_vld) begin
                    w_load      = 1'b1;
                    w_use_pend  = 1'b1;
                    w_state_nxt = S_CONV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_bin        <= 14'd0;
            r_bcd        <= 16'd0;
            r_iter       <= 4'd0;
            r_cv_point   <= 4'd0;
            r_cv_sign    <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_pend_data  <= 14'd0;
            r_pend_point <= 4'd0;
            r_pend_sign  <= 1'b0;
            r_disp_bcd   <= 16'd0;
            r_disp_point <= 4'd0;
            r_disp_sign  <= 1'b0;
        end else begin
            if (w_load) begin
                r_bin      <= w_src_data;
                r_bcd      <= 16'd0;
                r_iter     <= 4'd0;
                r_cv_point <= w_src_point;
                r_cv_sign  <= w_src_sign;
            end else if (r_state == S_CONV) begin
                r_bcd  <= {r_bcd[14:12], w_bcd_adj, r_bin[13]};
                r_bin  <= {r_bin[12:0], 1'b0};
                r_iter <= r_iter + 4'd1;
            end
            if (w_commit) begin
                r_disp_bcd   <= r_bcd;
                r_disp_point <= r_cv_point;
                r_disp_sign  <= r_cv_sign;
            end
            if (w_to_pend) begin
                r_pend_vld   <= 1'b1;
                r_pend_data  <= w_data_sat;
                r_pend_point <= point;
                r_pend_sign  <= sign;
            end else if (w_commit) begin
                r_pend_vld   <= 1'b0;
            end
        end
    end

    // Significance is monotonic from the top, so the minus goes just above it.
    always_comb begin
        w_sig[3] = w_nz[3] | r_disp_point[3];
        w_sig[2] = w_sig[3] | w_nz[2] | r_disp_point[2];
        w_sig[1] = w_sig[2] | w_nz[1] | r_disp_point[1];
        w_sig[0] = 1'b1;
        if (!w_sig[1])      w_minus_pos = 2'd1;
        else if (!w_sig[2]) w_minus_pos = 2'd2;
        else                w_minus_pos = 2'd3;
        w_minus_ok = r_disp_sign & ~w_sig[3];
        w_nibble   = r_disp_bcd[{r_dig, 2'b00} +: 4];
        if (w_sig[r_dig])                            w_seg_nxt = f_dec(w_nibble);
        else if (w_minus_ok && r_dig == w_minus_pos) w_seg_nxt = 8'hBF;
        else                                         w_seg_nxt = 8'hFF;
        if (r_disp_point[r_dig]) w_seg_nxt[7] = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_cnt <= 16'd0;
            r_dig <= 2'd0;
            r_sel <= 4'b0000;
            r_seg <= 8'hFF;
        end else begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= 16'd0;
                r_dig <= r_dig + 2'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (seg_en) begin
                r_sel <= 4'b0001 << r_dig;
                r_seg <= w_seg_nxt;
            end else begin
                r_sel <= 4'b0000;
                r_seg <= 8'hFF;
            end
        end
    end

    assign sel = r_sel;
    assign seg = r_seg;

endmodule
`default_nettype wire
